// File: rtl/bsd_pkg.sv
// Shared types and constants for the binary-sequence symmetry tile.
package bsd_pkg;

  localparam int DEPTH_MAX = 31;
  localparam int CNT_W     = 5;

  // ui_in pin positions
  localparam int BIT_IN    = 0;
  localparam int BIT_VALID = 1;
  localparam int START     = 2;
  localparam int CHECK     = 3;

  // uo_out pin positions
  localparam int SYM       = 0;
  localparam int DONE      = 1;
  localparam int BUSY      = 2;
  localparam int OVF       = 3;

  // Controller states; prefixed so they do not collide with the pin indices above
  typedef enum logic [1:0] {
    ST_IDLE,
    ST_LOAD,
    ST_CHECK,
    ST_DONE
  } state_t;

endpackage

// File: rtl/bsd_sync_edge.sv
// Two-flop synchroniser for an asynchronous pin, plus a third flop that turns
// each synchronised rising edge into a single-cycle pulse.
module bsd_sync_edge (
  input  logic clk,
  input  logic rst_n,
  input  logic din,
  output logic level,
  output logic pulse
);

  logic sync_1;
  logic sync_2;
  logic sync_3;

  // Shift the pin through the synchroniser and the edge-history flop
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync_1 <= 1'b0;
      sync_2 <= 1'b0;
      sync_3 <= 1'b0;
    end else begin
      sync_1 <= din;
      sync_2 <= sync_1;
      sync_3 <= sync_2;
    end
  end

  assign level = sync_2;
  assign pulse = sync_2 & ~sync_3;

endmodule

// File: rtl/tt_um_bsd_seq.sv
// Serial-frame symmetry controller: captures up to DEPTH bits, then compares
// mirror pairs one per cycle and reports a symmetric / not-symmetric verdict.
module tt_um_bsd_seq #(
  parameter int DEPTH = 16
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       ena,
  input  logic [7:0] ui_in,
  output logic [7:0] uo_out,
  input  logic [7:0] uio_in,
  output logic [7:0] uio_out,
  output logic [7:0] uio_oe
);

  import bsd_pkg::*;

  logic bit_lvl;
  logic bit_pulse_unused;
  logic bv_lvl;
  logic bv_pulse;
  logic start_lvl;
  logic start_pulse;
  logic check_lvl;
  logic check_pulse;

  bsd_sync_edge u_sync_bit (
    .clk   (clk),
    .rst_n (rst_n),
    .din   (ui_in[BIT_IN]),
    .level (bit_lvl),
    .pulse (bit_pulse_unused)
  );

  bsd_sync_edge u_sync_valid (
    .clk   (clk),
    .rst_n (rst_n),
    .din   (ui_in[BIT_VALID]),
    .level (bv_lvl),
    .pulse (bv_pulse)
  );

  bsd_sync_edge u_sync_start (
    .clk   (clk),
    .rst_n (rst_n),
    .din   (ui_in[START]),
    .level (start_lvl),
    .pulse (start_pulse)
  );

  bsd_sync_edge u_sync_check (
    .clk   (clk),
    .rst_n (rst_n),
    .din   (ui_in[CHECK]),
    .level (check_lvl),
    .pulse (check_pulse)
  );

  state_t           state, state_nx;
  logic [CNT_W-1:0] count, count_nx;
  logic [CNT_W-1:0] cap_count;
  logic [CNT_W-1:0] ptr_i, ptr_i_nx;
  logic [CNT_W-1:0] ptr_j, ptr_j_nx;
  logic [DEPTH-1:0] frame, frame_nx;
  logic [31:0]      frame_ext;
  logic             sym, sym_nx;
  logic             done, done_nx;
  logic             ovf, ovf_nx;
  logic             busy;

  // Widened copy so the 5-bit compare pointers index it without a range issue
  assign frame_ext = 32'(frame);
  assign busy      = (state == ST_CHECK);

  // Next-state logic: start wins everywhere, then check, then bit capture
  always_comb begin
    state_nx  = state;
    count_nx  = count;
    cap_count = count;
    ptr_i_nx  = ptr_i;
    ptr_j_nx  = ptr_j;
    frame_nx  = frame;
    sym_nx    = sym;
    done_nx   = done;
    ovf_nx    = ovf;

    if (start_pulse) begin
      state_nx = ST_LOAD;
      count_nx = '0;
      ovf_nx   = 1'b0;
      sym_nx   = 1'b0;
      done_nx  = 1'b0;
    end else begin
      case (state)
        ST_LOAD: begin
          if (bv_pulse) begin
            if (count < CNT_W'(DEPTH)) begin
              for (int k = 0; k < DEPTH; k++) begin
                if (count == CNT_W'(k)) frame_nx[k] = bit_lvl;
              end
              cap_count = count + CNT_W'(1);
            end else begin
              ovf_nx = 1'b1;
            end
          end
          count_nx = cap_count;
          if (check_pulse) begin
            if (cap_count <= CNT_W'(1)) begin
              state_nx = ST_DONE;
              sym_nx   = 1'b1;
              done_nx  = 1'b1;
            end else begin
              state_nx = ST_CHECK;
              ptr_i_nx = '0;
              ptr_j_nx = cap_count - CNT_W'(1);
            end
          end
        end
        ST_CHECK: begin
          if (frame_ext[ptr_i] != frame_ext[ptr_j]) begin
            state_nx = ST_DONE;
            sym_nx   = 1'b0;
            done_nx  = 1'b1;
          end else begin
            ptr_i_nx = ptr_i + CNT_W'(1);
            ptr_j_nx = ptr_j - CNT_W'(1);
            if (ptr_i_nx >= ptr_j_nx) begin
              state_nx = ST_DONE;
              sym_nx   = 1'b1;
              done_nx  = 1'b1;
            end
          end
        end
        ST_IDLE, ST_DONE: ;
        default: state_nx = ST_IDLE;
      endcase
    end
  end

  // State, frame buffer, pointers and flags; reset clears everything at once
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= ST_IDLE;
      count <= '0;
      ptr_i <= '0;
      ptr_j <= '0;
      frame <= '0;
      sym   <= 1'b0;
      done  <= 1'b0;
      ovf   <= 1'b0;
    end else begin
      state <= state_nx;
      count <= count_nx;
      ptr_i <= ptr_i_nx;
      ptr_j <= ptr_j_nx;
      frame <= frame_nx;
      sym   <= sym_nx;
      done  <= done_nx;
      ovf   <= ovf_nx;
    end
  end

  // Pack the status flags onto the output pins
  always_comb begin
    uo_out       = 8'h00;
    uo_out[SYM]  = sym;
    uo_out[DONE] = done;
    uo_out[BUSY] = busy;
    uo_out[OVF]  = ovf;
  end

  assign uio_out = {3'b000, count};
  assign uio_oe  = 8'b0001_1111;

  logic unused_ok;
  assign unused_ok = &{1'b0, ena, ui_in[7:4], uio_in, bit_pulse_unused,
                       bv_lvl, start_lvl, check_lvl};

endmodule

// File: tb/tb_tt_um_bsd_seq.sv
// Randomised and directed bench for tt_um_bsd_seq against a frame-level model.
module tb_tt_um_bsd_seq;

  localparam logic [7:0] P_BIT   = 8'h01;
  localparam logic [7:0] P_VALID = 8'h02;
  localparam logic [7:0] P_START = 8'h04;
  localparam logic [7:0] P_CHECK = 8'h08;
  localparam int         DEPTH   = 16;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       ena = 1'b1;
  logic [7:0] ui_in;
  logic [7:0] uio_in = 8'h00;
  logic [7:0] uo_out;
  logic [7:0] uio_out;
  logic [7:0] uio_oe;

  int total_checks  = 0;
  int passed_checks = 0;

  bit model_q[$];
  bit model_ovf;
  bit frame_bits[$];

  tt_um_bsd_seq #(.DEPTH(DEPTH)) dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .ena     (ena),
    .ui_in   (ui_in),
    .uo_out  (uo_out),
    .uio_in  (uio_in),
    .uio_out (uio_out),
    .uio_oe  (uio_oe)
  );

  always #5 clk = ~clk;

  task automatic checkOutput(input string tag, input int observed, input int expected);
    total_checks++;
    if (observed == expected) passed_checks++;
    else $display("[TB] FAIL %s: got %0d, expected %0d", tag, observed, expected);
  endtask

  // One legal pin pulse: high for two cycles, then low for two cycles
  task automatic applyStimulus(input logic [7:0] pins);
    @(negedge clk);
    ui_in = pins;
    repeat (2) @(negedge clk);
    ui_in = 8'h00;
    repeat (2) @(negedge clk);
  endtask

  function automatic void model_bit(input bit b);
    if (model_q.size() < DEPTH) model_q.push_back(b);
    else model_ovf = 1'b1;
  endfunction

  task automatic do_start();
    applyStimulus(P_START);
    model_q.delete();
    model_ovf = 1'b0;
    checkOutput("start_count", int'(uio_out), 0);
    checkOutput("start_flags", int'(uo_out), 0);
  endtask

  task automatic send_bit(input bit b);
    applyStimulus(P_VALID | (b ? P_BIT : 8'h00));
    model_bit(b);
    checkOutput("bit_count", int'(uio_out[4:0]), model_q.size());
    checkOutput("bit_ovf", int'(uo_out[3]), int'(model_ovf));
  endtask

  // Issue check (optionally with a final bit in the same pulse) and judge the verdict
  task automatic run_check(input bit with_bit, input bit b);
    int n, first_bad, exp_busy, busy_cycles;
    bit exp_sym, seen_done;
    if (with_bit) model_bit(b);
    n = model_q.size();
    exp_sym = 1'b1;
    first_bad = -1;
    for (int k = 0; k < n / 2; k++) begin
      if (model_q[k] != model_q[n - 1 - k]) begin
        exp_sym = 1'b0;
        if (first_bad < 0) first_bad = k;
      end
    end
    exp_busy = (n <= 1) ? 0 : (exp_sym ? n / 2 : first_bad + 1);

    @(negedge clk);
    ui_in = P_CHECK | (with_bit ? (P_VALID | (b ? P_BIT : 8'h00)) : 8'h00);
    busy_cycles = 0;
    seen_done = 1'b0;
    for (int c = 0; c < 100 && !seen_done; c++) begin
      @(negedge clk);
      if (uo_out[2]) busy_cycles++;
      if (uo_out[1]) seen_done = 1'b1;
    end
    ui_in = 8'h00;
    repeat (2) @(negedge clk);

    checkOutput("check_done", int'(seen_done), 1);
    checkOutput("check_sym", int'(uo_out[0]), int'(exp_sym));
    checkOutput("check_busy_cycles", busy_cycles, exp_busy);
    checkOutput("check_busy_low", int'(uo_out[2]), 0);
    checkOutput("check_count", int'(uio_out[4:0]), n);
    checkOutput("check_ovf", int'(uo_out[3]), int'(model_ovf));
  endtask

  task automatic send_frame(input bit last_with_check);
    int len;
    len = frame_bits.size();
    for (int k = 0; k < len; k++) begin
      if (!(last_with_check && k == len - 1)) send_bit(frame_bits[k]);
    end
    if (last_with_check && len > 0) run_check(1'b1, frame_bits[len - 1]);
    else run_check(1'b0, 1'b0);
  endtask

  initial begin
    int len, busy_wait;
    bit pal, combo;

    ui_in = 8'h00;
    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    checkOutput("reset_uo_out", int'(uo_out), 8'h00);
    checkOutput("reset_uio_out", int'(uio_out), 8'h00);
    checkOutput("reset_uio_oe", int'(uio_oe), 8'h1F);
    rst_n = 1'b1;

    // IDLE ignores bits and check
    applyStimulus(P_VALID | P_BIT);
    checkOutput("idle_bit_ignored", int'(uio_out), 0);
    applyStimulus(P_CHECK);
    checkOutput("idle_check_ignored", int'(uo_out), 0);

    // Symmetric frame 1,0,1,1,0,1
    do_start();
    frame_bits = '{1, 0, 1, 1, 0, 1};
    send_frame(1'b0);

    // Asymmetric frame 1,0,0,1,1
    do_start();
    frame_bits = '{1, 0, 0, 1, 1};
    send_frame(1'b0);

    // Overflow: 17 alternating bits
    do_start();
    frame_bits.delete();
    for (int k = 0; k < 17; k++) frame_bits.push_back(bit'(k % 2 == 0));
    send_frame(1'b0);

    // Empty frame
    do_start();
    frame_bits.delete();
    send_frame(1'b0);

    // Third bit arrives together with check
    do_start();
    frame_bits = '{1, 1, 1};
    send_frame(1'b1);

    // Abort during CHECK of a 16-bit palindrome
    do_start();
    for (int k = 0; k < 8; k++) send_bit(bit'(k % 3 == 0));
    for (int k = 7; k >= 0; k--) send_bit(bit'(k % 3 == 0));
    @(negedge clk);
    ui_in = P_CHECK;
    busy_wait = 0;
    while (!uo_out[2] && busy_wait < 20) begin
      @(negedge clk);
      busy_wait++;
    end
    checkOutput("abort_busy_seen", int'(uo_out[2]), 1);
    ui_in = P_CHECK | P_START;
    repeat (3) @(negedge clk);
    checkOutput("abort_busy", int'(uo_out[2]), 0);
    checkOutput("abort_done", int'(uo_out[1]), 0);
    checkOutput("abort_count", int'(uio_out), 0);
    ui_in = 8'h00;
    repeat (2) @(negedge clk);
    model_q.delete();
    model_ovf = 1'b0;
    send_bit(1'b1);
    send_bit(1'b0);
    run_check(1'b0, 1'b0);

    // Randomised frames, half of them palindromes, some ending with a combined pulse
    for (int t = 0; t < 10; t++) begin
      do_start();
      len = $urandom_range(0, 19);
      pal = bit'($urandom_range(0, 1));
      combo = ($urandom_range(0, 2) == 0);
      frame_bits.delete();
      for (int k = 0; k < len; k++) begin
        if (pal && 2 * k >= len) frame_bits.push_back(frame_bits[len - 1 - k]);
        else frame_bits.push_back(bit'($urandom_range(0, 1)));
      end
      send_frame(combo);
    end

    // Reset mid-frame clears everything and returns to IDLE
    do_start();
    send_bit(1'b1);
    send_bit(1'b1);
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    checkOutput("midreset_uo_out", int'(uo_out), 8'h00);
    checkOutput("midreset_uio_out", int'(uio_out), 8'h00);
    checkOutput("midreset_uio_oe", int'(uio_oe), 8'h1F);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    applyStimulus(P_VALID | P_BIT);
    checkOutput("post_reset_idle_count", int'(uio_out), 0);
    applyStimulus(P_CHECK);
    checkOutput("post_reset_idle_flags", int'(uo_out), 0);

    $display("%0d/%0d checks passed", passed_checks, total_checks);
    $finish;
  end

endmodule

// File: doc/tt_um_bsd_seq.md
# tt_um_bsd_seq

Serial-frame symmetry controller for the binary-sequence tile. It captures a bit stream one bit at a time into a DEPTH-bit buffer and, on command, runs the pairwise mirror compare across the captured length, using one compare per cycle. It reports a symmetric/not-symmetric verdict with done, busy and overflow flags. It is a TinyTapeout top: pins are hand- or MCU-driven, so all control inputs are synchronised and edge-detected.

## Interface
- DEPTH, 16: maximum frame length in bits; legal range 2..31.
- clk  in  1  clock.
- rst_n  in  1  reset; asynchronous, active-low; all flops clear immediately.
- ena  in  1  always 1; ignored.
- ui_in  in  8  [0] bit_in, [1] bit_valid, [2] start, [3] check, [7:4] unused.
- uo_out  out  8  [0] sym, [1] done, [2] busy, [3] ovf, [7:4] 0.
- uio_in  in  8  unused.
- uio_out  out  8  [4:0] count (captured bits), [7:5] 0.
- uio_oe  out  8  constant 8'b0001_1111.

## Operation
- Input conditioning:
  - bit_in, bit_valid, start and check each pass a 2-flop synchroniser.
  - bit_valid, start and check then go through a rising-edge detector (third flop), giving one action per pin pulse.
  - bit_in is sampled at its synchronised level, aligned with the bit_valid pulse.
- States: IDLE, LOAD, CHECK, DONE. Reset state is IDLE.
- Event priority in every state: start > check > bit_valid.
- IDLE: start → LOAD with count=0, ovf=0, sym=0, done=0. All other events are ignored.
- LOAD, capture:
  - If count<DEPTH, a bit_valid pulse writes buf[count]=bit_in and increments count.
  - If count==DEPTH, a bit_valid pulse drops the bit and sets ovf. ovf is sticky until the next start.
- LOAD, check pulse:
  - Any bit_valid pulse in the same cycle is captured first and included in the frame.
  - count≤1 → DONE with sym=1 (empty and single-bit frames are symmetric).
  - Otherwise → CHECK with i=0, j=count−1.
- CHECK: one compare per cycle.
  - buf[i]≠buf[j] → DONE, sym=0.
  - Otherwise i++ and j--. When the new i≥j → DONE, sym=1.
  - bit_valid and check are ignored.
  - start aborts to LOAD and clears count, ovf, done and sym.
- DONE: done=1 and sym is held. bit_valid and check are ignored. start → LOAD (new frame, flags cleared).
- busy=1 only in CHECK.
- Width rules:
  - count is 5 bits wide.
  - i and j are 5 bits wide. j is computed only when count≥2, so there is no underflow.
- Reset mid-operation: immediate return to IDLE with all outputs 0. The buffer contents are don't-care after reset.

## Timing
- Reset values: uo_out=0x00, uio_out=0x00, uio_oe=0x1F.
- Pin-to-action latency:
  - A pin first sampled high at edge E0 takes effect at edge E2.
  - The register update is visible after E2.
- Pin pulse width rules: high ≥2 cycles, then low ≥2 cycles before the next pulse on the same pin.
- CHECK duration: a symmetric frame of n≥2 bits takes floor(n/2) cycles; a mismatch exits on the cycle of the first mismatching pair.
- Output timing:
  - done, sym and busy are registered and change together on the CHECK→DONE edge.
  - count updates on the edge that captures the bit.

## Structure
- Package bsd_pkg holds:
  - the state enum {IDLE, LOAD, CHECK, DONE};
  - DEPTH_MAX=31 and CNT_W=5;
  - pin index localparams: BIT_IN=0, BIT_VALID=1, START=2, CHECK=3, SYM=0, DONE=1, BUSY=2, OVF=3.
- Sub-module bsd_sync_edge: 2-flop synchroniser plus rising-edge pulse, asynchronous active-low reset; outputs both level and pulse.
  - Instantiated for bit_valid, start and check.
  - bit_in uses its level output only.
- FSM, buffer and compare pointers live in tt_um_bsd_seq.

## Test plan
- Reset: hold rst_n=0 mid-frame → uo_out=0x00, uio_out=0x00, uio_oe=0x1F; state IDLE after release.
- Symmetric frame: start, bits 1,0,1,1,0,1, then check → count=6, busy for 3 cycles, then done=1 and sym=1.
- Asymmetric frame: start, bits 1,0,0,1,1, then check → mismatch on the 2nd compare (buf[1]=0 vs buf[3]=1), done=1 and sym=0 after 2 CHECK cycles.
- Overflow: start, then 17 bit_valid pulses with alternating bits → count=16 and ovf=1. check evaluates the first 16 bits only (1010…10 gives sym=0).
- Empty and simultaneous events:
  - start then check with no bits → done=1, sym=1, count=0.
  - bit_valid and check in the same cycle after bits 1,1 → the third bit is included, count=3, sym=1.
- Abort: start during CHECK of a 16-bit frame → busy=0, done=0, count=0, state LOAD; a subsequent bit pulse is captured at buf[0].
